// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Constants shared by the keyboard receive path: the ASCII
//               carriage-return and line-feed codes used by the Enter
//               expansion logic.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage : kbd_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock circular-buffer FIFO with show-ahead head data.
//               The caller must never push into a full FIFO unless it pops
//               in the same cycle, and must never pop an empty FIFO.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               push      - write push_data at the tail
//               push_data - data to write
//               pop       - discard the head entry
//               head_data - raw storage at the read pointer (not gated)
//               count     - number of entries held, 0 .. 2**DEPTH_LOG2
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    // Storage carries no reset; reads are only meaningful when count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally through their DEPTH_LOG2-bit width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/kbd_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : kbd_rx_buffer
// Description : Receive buffer between the PS/2 keyboard decoder and the CPU
//               console interface. Enter (0x0A) is expanded into CR LF as an
//               all-or-nothing pair; characters are queued in a FIFO and read
//               through a show-ahead port with a sticky overrun flag.
// Ports       : clk_in       - clock, rising edge
//               rst_in       - asynchronous active-high reset
//               key_data_in  - ASCII code, valid with key_ready_in
//               key_ready_in - one-cycle character strobe
//               rd_in        - CPU read strobe, pops the head entry
//               data_out     - head entry, 0x00 when empty
//               avail_out    - FIFO non-empty
//               overrun_out  - sticky: a character was dropped
//               count_out    - entries held, 0 .. 2**DEPTH_LOG2
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_rx_buffer
    import kbd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [7:0]            key_data_in,
    input  logic                  key_ready_in,
    input  logic                  rd_in,
    output logic [7:0]            data_out,
    output logic                  avail_out,
    output logic                  overrun_out,
    output logic [DEPTH_LOG2:0]   count_out
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam int                    FW         = DEPTH_LOG2 + 2;
    localparam logic [FW-1:0]         FREE_DEPTH = FW'(DEPTH);
    localparam logic [FW-1:0]         FREE_ONE   = FW'(1);
    localparam logic [FW-1:0]         FREE_TWO   = FW'(2);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PUSH_LF = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_next_state;
    logic                r_overrun;
    logic [7:0]          w_head;
    logic [DEPTH_LOG2:0] w_count;
    logic                w_avail;
    logic                w_pop;
    logic [FW-1:0]       w_free;
    logic                w_push;
    logic [7:0]          w_push_data;
    logic                w_drop;
    logic                w_is_lf;

    assign w_avail = (w_count != '0);
    assign w_pop   = rd_in & w_avail;
    assign w_is_lf = (key_data_in == ASCII_LF);

    // A pop in the same cycle frees a slot that this cycle's push may use.
    assign w_free = FREE_DEPTH - {1'b0, w_count} + {{(FW-1){1'b0}}, w_pop};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // Only enter PUSH_LF when both halves of the pair fit.
                if (key_ready_in && w_is_lf && (w_free >= FREE_TWO)) begin
                    w_next_state = ST_PUSH_LF;
                end
            end
            ST_PUSH_LF: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_push      = 1'b0;
        w_push_data = 8'h00;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (key_ready_in) begin
                    if (w_is_lf) begin
                        if (w_free >= FREE_TWO) begin
                            w_push      = 1'b1;
                            w_push_data = ASCII_CR;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end else if (w_free >= FREE_ONE) begin
                        w_push      = 1'b1;
                        w_push_data = key_data_in;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            ST_PUSH_LF: begin
                // The slot was reserved when the CR was accepted.
                w_push      = 1'b1;
                w_push_data = ASCII_LF;
                w_drop      = key_ready_in;
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    // Overrun: a drop sets it and takes priority over the clear by a read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (w_pop) begin
            r_overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (w_push),
        .push_data  (w_push_data),
        .pop        (w_pop),
        .head_data  (w_head),
        .count      (w_count)
    );

    assign data_out    = w_avail ? w_head : 8'h00;
    assign avail_out   = w_avail;
    assign overrun_out = r_overrun;
    assign count_out   = w_count;

endmodule : kbd_rx_buffer
`default_nettype wire

// File: doc/kbd_rx_buffer.md
# kbd_rx_buffer

Receive buffer between the PS/2 `keyboard` block and the CPU-side serial/console register interface. It accepts one-cycle ASCII strobes from `keyboard`, expands Enter (0x0A) into the CR LF pair (0x0D, 0x0A), and queues characters in a small synchronous FIFO. The CPU drains the FIFO at its own pace through a show-ahead read port with an availability flag and a sticky overrun flag.

## Interface

Parameters:
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 entries (8 by default). Legal range is 1 to 6.

Ports:
- `clk_in`, input, 1: the single clock; all state is on its rising edge.
- `rst_in`, input, 1: reset, asynchronous and active-high.
- `key_data_in`, input, 8: ASCII code from `keyboard`.
- `key_ready_in`, input, 1: one-cycle strobe; `key_data_in` is valid in that cycle.
- `rd_in`, input, 1: CPU read strobe; pops the head entry.
- `data_out`, output, 8: head entry (show-ahead); 0x00 when the FIFO is empty.
- `avail_out`, output, 1: FIFO is non-empty.
- `overrun_out`, output, 1: sticky; at least one character was dropped.
- `count_out`, output, DEPTH_LOG2+1: number of entries held, from 0 to 2^DEPTH_LOG2.

## Operation

- Storage: a circular buffer with `wr_ptr` and `rd_ptr`, each DEPTH_LOG2 bits, plus a `count` register. Pointers wrap modulo 2^DEPTH_LOG2.
- Insertion FSM has two states: IDLE and PUSH_LF.
  - IDLE, `key_ready_in` with data not equal to 0x0A: push the data if at least 1 entry is free; otherwise drop it and set overrun.
  - IDLE, `key_ready_in` with data equal to 0x0A: if at least 2 entries are free, push 0x0D and go to PUSH_LF. Otherwise drop both characters (the pair is all-or-nothing), set overrun, and stay in IDLE.
  - PUSH_LF: push 0x0A unconditionally (space was reserved) and return to IDLE.
  - PUSH_LF with `key_ready_in` asserted: drop the new character and set overrun.
- Free-space checks use the current `count` plus the pop happening in the same cycle, i.e. free = DEPTH − count + (rd_in & avail).
- Read: `rd_in` while `avail_out`=1 advances `rd_ptr`. `rd_in` while empty is ignored, with no state change.
- Push and pop in the same cycle are both performed. `count` is unchanged. This also holds when full: the pop frees the slot the push uses.
- Overrun: set on any drop. Cleared by an accepted read (`rd_in` & `avail_out`). If a set and a clear fall in the same cycle, set wins.
- Arithmetic: `count` has DEPTH_LOG2+1 bits and never exceeds 2^DEPTH_LOG2 or goes below 0. Empty means count == 0; full means count == 2^DEPTH_LOG2.

## Timing

- Reset: applies immediately, without waiting for a clock edge. After reset, `wr_ptr`=`rd_ptr`=0, `count_out`=0, FSM in IDLE, `data_out`=0x00, `avail_out`=0, `overrun_out`=0.
- Reset in the middle of a CR LF expansion abandons the pending LF. Any characters already queued are lost.
- Latency, push: a character strobed in cycle N appears on `data_out`/`avail_out`/`count_out` in cycle N+1.
- Latency, expansion: for Enter, 0x0D is written at N+1 and 0x0A at N+2. `count_out` rises by 1 in each of those cycles.
- Latency, pop: after `rd_in` in cycle N, the next entry, or 0x00 if the FIFO is now empty, is presented in cycle N+1.
- `data_out` is driven combinationally from the registered storage and `rd_ptr`, gated by `avail_out`. It contains no comparator path from `rd_in`.
- `avail_out` and `overrun_out` are registered or derived directly from registers. There are no combinational paths from any input to any output.

## Structure

- Shared package `kbd_pkg` holds the constants `ASCII_CR`=8'h0D and `ASCII_LF`=8'h0A.
- One sub-module, `sync_fifo`:
  - Parameterised width and depth.
  - Ports: push, push_data, pop, head_data, count.
  - Asynchronous active-high reset.
- `kbd_rx_buffer` keeps the insertion FSM, the free-space check and the overrun logic.

## Test plan

- Reset, then strobe 'A' (0x41) → next cycle `data_out`=0x41, `avail_out`=1, `count_out`=1. Pulse `rd_in` → `data_out`=0x00, `avail_out`=0.
- Strobe 0x0A → `count_out` reads 1 then 2. Successive reads return 0x0D then 0x0A.
- Default depth 8: push 8 characters, then strobe 'Z' → `count_out` stays 8 and `overrun_out`=1. Read once → `overrun_out`=0 and FIFO holds 7.
- With `count_out`=7, strobe 0x0A → nothing is written, `count_out`=7, `overrun_out`=1. Repeat with `rd_in` in the same cycle → CR and LF both accepted and count ends at 8.
- With the FIFO full, assert `key_ready_in`('Q') and `rd_in` in the same cycle → count stays 8, no overrun, and 'Q' is last out. Also check pointer wrap by pushing and popping 20 characters in sequence.
- Assert `rst_in` asynchronously between the CR push and the LF push → all outputs are zero immediately. After release, the next strobe is stored at slot 0.
